// File: rtl/turn_sequencer.sv
// Round controller for the cat-and-dog artillery game: readiness, aiming window,
// projectile flight watchdog, hit-point settle and winner decision.
module turn_sequencer #(
    parameter int unsigned CLK_HZ        = 60_000_000,
    parameter int unsigned AIM_TIME_S    = 10,
    parameter int unsigned FLIGHT_MAX_S  = 4,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic       clk60MHz,
    input  logic       rst,
    input  logic       player1_ready,
    input  logic       player2_ready,
    input  logic       throw_flag,
    input  logic       in_throw_flag,
    input  logic       end_throw,
    input  logic [6:0] hp_player1,
    input  logic [6:0] hp_player2,
    output logic [2:0] turn,
    output logic       aim_en,
    output logic       flight,
    output logic [3:0] seconds_left,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] state_dbg
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned SW = $clog2(SETTLE_CYCLES);

    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    AIM_LOAD   = 4'(AIM_TIME_S);
    localparam logic [3:0]    WD_MAX     = 4'(FLIGHT_MAX_S - 1);

    typedef enum logic [2:0] {
        WAIT_READY = 3'd0,
        AIM        = 3'd1,
        FLIGHT     = 3'd2,
        SETTLE     = 3'd3,
        GAME_OVER  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            thr_q;
    logic            thr_prev;
    logic            throw_evt;
    logic            sec_tick;
    logic            both_ready;
    logic [PW-1:0]   presc;
    logic [PW-1:0]   presc_next;
    logic [3:0]      wd;
    logic [3:0]      wd_next;
    logic [SW-1:0]   settle;
    logic [SW-1:0]   settle_next;
    logic [2:0]      turn_next;
    logic [3:0]      secs_next;
    logic [1:0]      winner_next;

    assign both_ready = player1_ready & player2_ready;
    assign throw_evt  = thr_q & ~thr_prev;
    assign sec_tick   = ((state == AIM) || (state == FLIGHT)) && (presc == PRESC_MAX);

    // Next-state, counters and turn bookkeeping
    always_comb begin
        state_next  = state;
        turn_next   = turn;
        secs_next   = seconds_left;
        winner_next = winner;
        presc_next  = '0;
        wd_next     = wd;
        settle_next = '0;

        if ((state == AIM) || (state == FLIGHT)) begin
            presc_next = sec_tick ? '0 : presc + 1'b1;
        end

        case (state)
            WAIT_READY: begin
                if (both_ready) begin
                    state_next = AIM;
                    secs_next  = AIM_LOAD;
                end
            end
            AIM: begin
                if (throw_evt) begin
                    state_next = FLIGHT;
                    presc_next = '0;
                    wd_next    = '0;
                end else if (!both_ready) begin
                    state_next = WAIT_READY;
                end else if (sec_tick) begin
                    if (seconds_left != 4'd0) begin
                        secs_next = seconds_left - 4'd1;
                    end else begin
                        turn_next  = turn + 3'd1;
                        secs_next  = AIM_LOAD;
                        presc_next = '0;
                    end
                end
            end
            FLIGHT: begin
                if (end_throw) begin
                    state_next = SETTLE;
                end else if (sec_tick) begin
                    if (wd == WD_MAX) begin
                        state_next = SETTLE;
                    end else begin
                        wd_next = wd + 4'd1;
                    end
                end
            end
            SETTLE: begin
                // Hit points are sampled only once the damage update has had time to land
                if (settle == SETTLE_MAX) begin
                    if ((hp_player1 == 7'd0) && (hp_player2 == 7'd0)) begin
                        state_next  = GAME_OVER;
                        winner_next = 2'b11;
                    end else if (hp_player1 == 7'd0) begin
                        state_next  = GAME_OVER;
                        winner_next = 2'b10;
                    end else if (hp_player2 == 7'd0) begin
                        state_next  = GAME_OVER;
                        winner_next = 2'b01;
                    end else begin
                        state_next = AIM;
                        turn_next  = turn + 3'd1;
                        secs_next  = AIM_LOAD;
                    end
                end else begin
                    settle_next = settle + 1'b1;
                end
            end
            GAME_OVER: begin
                state_next = GAME_OVER;
            end
            default: begin
                state_next = WAIT_READY;
            end
        endcase
    end

    // State, counters and registered output decode
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state        <= WAIT_READY;
            turn         <= '0;
            seconds_left <= AIM_LOAD;
            winner       <= '0;
            presc        <= '0;
            wd           <= '0;
            settle       <= '0;
            thr_q        <= 1'b0;
            thr_prev     <= 1'b0;
            aim_en       <= 1'b0;
            flight       <= 1'b0;
            game_over    <= 1'b0;
            state_dbg    <= '0;
        end else begin
            state        <= state_next;
            turn         <= turn_next;
            seconds_left <= secs_next;
            winner       <= winner_next;
            presc        <= presc_next;
            wd           <= wd_next;
            settle       <= settle_next;
            thr_q        <= throw_flag | in_throw_flag;
            thr_prev     <= thr_q;
            aim_en       <= (state_next == AIM);
            flight       <= (state_next == FLIGHT);
            game_over    <= (state_next == GAME_OVER);
            state_dbg    <= state_next;
        end
    end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Central game-flow controller for the cat-and-dog artillery game.
- Sequences each round as follows: wait until both players are ready, open an aiming window for the current player, track the projectile flight, let the hit-point update settle, then either pass the turn or declare a winner.
- Owns the turn counter consumed by set_wind, set_speed, throw, simulate and draw_particle. It also supplies the aim/flight enables and the end-of-game indication.

Parameters:
- CLK_HZ, 60_000_000, clock cycles per second (prescaler terminal count + 1).
- AIM_TIME_S, 10, seconds allowed to throw; range 1..15.
- FLIGHT_MAX_S, 4, flight watchdog in seconds; range 1..15.
- SETTLE_CYCLES, 16, cycles to wait after flight before sampling hit points; range ≥2.

Ports:
- clk60MHz  in  1  system clock
- rst  in  1  synchronous, active-high reset
- player1_ready  in  1  level, player 1 ready (local or remote copy)
- player2_ready  in  1  level, player 2 ready
- throw_flag  in  1  local throw request, level
- in_throw_flag  in  1  remote throw request, level
- end_throw  in  1  projectile landed/left screen, one-cycle pulse
- hp_player1  in  7  player 1 hit points
- hp_player2  in  7  player 2 hit points
- turn  out  3  turn counter; turn[0]=0 means player 1 throws
- aim_en  out  1  aiming window open
- flight  out  1  projectile in flight
- seconds_left  out  4  remaining aim seconds
- game_over  out  1  game finished, sticky
- winner  out  2  00 none, 01 player1, 10 player2, 11 draw
- state_dbg  out  3  state encoding for debug/ILA

Behaviour:
- Clock, reset and registering:
  - Single clock; all registers update on the rising edge of clk60MHz.
  - rst is synchronous and active-high. It has priority over every other input, in any state, including mid-flight.
  - All outputs are registered and are a decode of the current state/counters, valid in the same cycle as the state.
- Reset values:
  - state = WAIT_READY (0), turn = 0, aim_en = 0, flight = 0.
  - seconds_left = AIM_TIME_S, game_over = 0, winner = 00.
  - Prescaler = 0, settle counter = 0.
- Throw edge:
  - thr = throw_flag | in_throw_flag, registered once.
  - A throw event is a rising edge of thr (thr=1, previous=0).
  - Throw events outside AIM are ignored. A level held high across entry into AIM does not fire until it drops and rises again.
- Prescaler:
  - Counts 0..CLK_HZ-1 only in AIM and FLIGHT.
  - Cleared on every entry to AIM or FLIGHT.
  - sec_tick is asserted when the count equals CLK_HZ-1.
- States (state_dbg):
  - WAIT_READY (0): aim_en=0, flight=0. When player1_ready & player2_ready are both 1, go to AIM next cycle and load seconds_left=AIM_TIME_S.
  - AIM (1): aim_en=1.
    - A throw event goes to FLIGHT; turn is unchanged.
    - Otherwise, sec_tick with seconds_left>0 decrements seconds_left.
    - sec_tick with seconds_left==0 is a forfeit: turn+1, reload seconds_left, stay in AIM with the prescaler cleared.
    - Either ready dropping to 0 goes to WAIT_READY; turn and seconds_left are held.
    - Priority: throw > ready drop > timeout.
  - FLIGHT (2): flight=1; ready inputs are ignored.
    - end_throw goes to SETTLE.
    - The watchdog counts sec_ticks. Reaching FLIGHT_MAX_S without end_throw also goes to SETTLE.
    - end_throw arriving in any other state is ignored.
  - SETTLE (3): wait SETTLE_CYCLES cycles, then evaluate hp_player1/hp_player2:
    - both == 0: GAME_OVER, winner=11.
    - hp_player1 == 0: GAME_OVER, winner=10.
    - hp_player2 == 0: GAME_OVER, winner=01.
    - else: turn+1, seconds_left=AIM_TIME_S, go to AIM.
  - GAME_OVER (4): game_over=1, aim_en=0, flight=0. Sticky; all inputs are ignored until rst.
- Arithmetic:
  - turn is a 3-bit modulo-8 counter that wraps 7→0.
  - seconds_left never underflows; it saturates at 0 until the forfeit reload.
- Encodings 5..7 are illegal and recover to WAIT_READY on the next cycle.

Test Plan:
- Reset and ready: CLK_HZ=100. Assert rst for 2 cycles → all reset values. Raise player1_ready then player2_ready → AIM one cycle after both are high, aim_en=1, seconds_left=10, turn=0.
- Throw and pass:
  - In AIM, pulse throw_flag → flight=1 two cycles later.
  - Pulse end_throw with hp 50/50 → after 16 settle cycles: AIM, turn=1, seconds_left=10.
  - Repeat with in_throw_flag → turn=2.
- Timeout forfeit: CLK_HZ=100, AIM_TIME_S=2, no throw → seconds_left 2→1→0 at 100-cycle intervals. On the third tick turn increments, seconds_left=2, still AIM. Throw coinciding with the tick → FLIGHT, turn unchanged.
- Flight watchdog: CLK_HZ=100, FLIGHT_MAX_S=4. Throw, never pulse end_throw → SETTLE after 400 cycles, then AIM with turn+1.
- Win/draw:
  - Flight ending with hp_player2=0 → game_over=1, winner=01; subsequent throws and ready toggles have no effect.
  - Rerun with both hp=0 → winner=11.
  - Rerun with hp_player1=0 → winner=10.
- Reset mid-flight and wrap: assert rst while flight=1 → WAIT_READY, turn=0 next cycle. Play 8 passed turns → turn wraps 7→0.
